// File: rtl/memory_pkg.sv
// Shared types and constants for the MEM stage.
// Bus FSM states, abort codes and the MEM/WB bundle.
package memory_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mstate_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic        err;
    logic [1:0]  err_code;
  } mem_wb_t;

  function automatic logic word_aligned(
    input logic [31:0] addr
  );
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/memory_cycle_dmem_bus_ctrl.sv
// Data-memory handshake control for the MEM stage.
// Tracks wait cycles and decides req, stall and abort.
module dmem_bus_ctrl
  import memory_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       access_i,
  input  logic       aligned_i,
  input  logic       ack_i,
  output logic       req_o,
  output logic       stall_o,
  output logic       abort_o,
  output logic [1:0] err_code_o
);

  localparam logic             TMO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mstate_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_hit;

  // State and wait counter, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: enter WAIT on an unacked request, leave on ack or abort
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_o && !ack_i) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (ack_i || abort_o) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((!TMO_EN || cnt_q != TMO_CNT) &&
                     cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: ack beats timeout; reset silences the bus
  always_comb begin
    tmo_hit    = TMO_EN && (cnt_q == TMO_CNT) && !ack_i;
    abort_o    = access_i && (!aligned_i || tmo_hit);
    req_o      = rst_ni && access_i && aligned_i && !abort_o;
    stall_o    = req_o && !ack_i;
    err_code_o = ERR_NONE;
    if (abort_o) begin
      err_code_o = aligned_i ? ERR_TIMEOUT : ERR_MISALIGN;
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// MEM stage of the RV32I pipeline.
// Drives the data bus and owns the MEM/WB register.
module memory_cycle
  import memory_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        ErrW,
  output logic [1:0]  ErrCodeW
);

  logic       access;
  logic       aligned;
  logic       abort;
  logic [1:0] err_code;
  mem_wb_t    wb_q, wb_d;

  assign access     = MemWriteM | ResultSrcM;
  assign aligned    = word_aligned(ALU_ResultM);
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALU_ResultM;
  assign dmem_wdata = WriteDataM;

  dmem_bus_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_bus (
    .clk_i      (clk),
    .rst_ni     (rst),
    .access_i   (access),
    .aligned_i  (aligned),
    .ack_i      (dmem_ack),
    .req_o      (dmem_req),
    .stall_o    (StallM),
    .abort_o    (abort),
    .err_code_o (err_code)
  );

  // MEM/WB next value: bubble on stall, error bubble on abort
  always_comb begin
    wb_d = '0;
    unique case (1'b1)
      StallM: wb_d = '0;
      abort: begin
        wb_d.err      = 1'b1;
        wb_d.err_code = err_code;
      end
      default: begin
        wb_d.reg_write  = RegWriteM;
        wb_d.result_src = ResultSrcM;
        wb_d.rd         = RD_M;
        wb_d.pc_plus4   = PCPlus4M;
        wb_d.alu_result = ALU_ResultM;
        if (ResultSrcM && dmem_ack) begin
          wb_d.read_data = dmem_rdata;
        end
      end
    endcase
  end

  // MEM/WB register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign RegWriteW   = wb_q.reg_write;
  assign ResultSrcW  = wb_q.result_src;
  assign RD_W        = wb_q.rd;
  assign PCPlus4W    = wb_q.pc_plus4;
  assign ALU_ResultW = wb_q.alu_result;
  assign ReadDataW   = wb_q.read_data;
  assign ErrW        = wb_q.err;
  assign ErrCodeW    = wb_q.err_code;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for the MEM stage.
// Directed cases plus random ops against a per-instruction model.
module tb_memory_cycle;

  localparam int TMO = 4;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        StallM;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic        ErrW;
  logic [1:0]  ErrCodeW;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_cycle #(
    .TIMEOUT (TMO),
    .CNT_W   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .StallM      (StallM),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .PCPlus4W    (PCPlus4W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .ErrW        (ErrW),
    .ErrCodeW    (ErrCodeW)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag,
                       input logic rw, rs,
                       input logic [4:0] rd,
                       input logic [31:0] pc, alu, rdat,
                       input logic err,
                       input logic [1:0] code);
    chk({tag, ".RegWriteW"}, RegWriteW, rw);
    chk({tag, ".ResultSrcW"}, ResultSrcW, rs);
    chk({tag, ".RD_W"}, RD_W, rd);
    chk({tag, ".PCPlus4W"}, PCPlus4W, pc);
    chk({tag, ".ALU_ResultW"}, ALU_ResultW, alu);
    chk({tag, ".ReadDataW"}, ReadDataW, rdat);
    chk({tag, ".ErrW"}, ErrW, err);
    chk({tag, ".ErrCodeW"}, ErrCodeW, code);
  endtask

  task automatic drive(input logic rw, ws, rs,
                       input logic [4:0] rd,
                       input logic [31:0] pc, wd, addr);
    RegWriteM   = rw;
    MemWriteM   = ws;
    ResultSrcM  = rs;
    RD_M        = rd;
    PCPlus4M    = pc;
    WriteDataM  = wd;
    ALU_ResultM = addr;
  endtask

  // One instruction held in M until it retires. The memory acks in
  // request cycle k (k=0 is the first cycle), or never if k > TMO.
  // Model: aligned access retires at cycle k if k<=TMO, stalling every
  // cycle before; otherwise it aborts at cycle TMO with a timeout.
  task automatic run_instr(input string tag,
                           input logic rw, ws, rs,
                           input logic [4:0] rd,
                           input logic [31:0] pc, wd, addr,
                           input int k);
    logic        is_mem, al, done, e_req, e_stall;
    logic        e_err;
    logic [1:0]  e_code;
    logic [31:0] rsample;
    drive(rw, ws, rs, rd, pc, wd, addr);
    is_mem = ws | rs;
    al = (addr % 4) == 0;
    for (int c = 0; c <= TMO; c++) begin
      dmem_ack   = (c == k);
      dmem_rdata = $urandom;
      rsample    = dmem_rdata;
      e_err = 1'b0;
      e_code = 2'b00;
      if (!is_mem) begin
        e_req = 0; e_stall = 0; done = 1;
      end else if (!al) begin
        e_req = 0; e_stall = 0; done = 1;
        e_err = 1; e_code = 2'b01;
      end else if (c == k) begin
        e_req = 1; e_stall = 0; done = 1;
      end else if (c == TMO) begin
        e_req = 0; e_stall = 0; done = 1;
        e_err = 1; e_code = 2'b10;
      end else begin
        e_req = 1; e_stall = 1; done = 0;
      end
      @(negedge clk);
      chk({tag, ".dmem_req"}, dmem_req, e_req);
      chk({tag, ".StallM"}, StallM, e_stall);
      if (e_req) begin
        chk({tag, ".dmem_we"}, dmem_we, ws);
        chk({tag, ".dmem_addr"}, dmem_addr, addr);
        chk({tag, ".dmem_wdata"}, dmem_wdata, wd);
      end
      @(posedge clk);
      #1;
      if (!done || e_err) begin
        chk_w(tag, 0, 0, 0, 0, 0, 0, e_err, e_code);
      end else begin
        chk_w(tag, rw, rs, rd, pc, addr,
              (rs && c == k) ? rsample : 32'h0, 0, 2'b00);
      end
      if (done) break;
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    int kind, k;
    logic [31:0] a;

    // Reset held with an access pending
    rst = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(1, 0, 1, 5'd7, 32'h44, 32'h0, 32'h100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst.dmem_req", dmem_req, 0);
      chk("rst.StallM", StallM, 0);
      @(posedge clk);
      #1;
      chk_w("rst", 0, 0, 0, 0, 0, 0, 0, 2'b00);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Directed cases
    run_instr("zw_load", 1, 0, 1, 5'd5, 32'h8, 0,
              32'h100, 0);
    chk("zw_load.data", ReadDataW, ReadDataW === 32'hx ? 0 : ReadDataW);
    drive(1, 0, 1, 5'd5, 32'hC, 0, 32'h100);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("zw_dead.StallM", StallM, 0);
    @(posedge clk);
    #1;
    chk_w("zw_dead", 1, 1, 5'd5, 32'hC, 32'h100,
          32'hDEADBEEF, 0, 2'b00);
    dmem_ack = 1'b0;

    run_instr("ws_store", 0, 1, 0, 5'd0, 32'h10, 32'h1234,
              32'h204, 3);
    run_instr("misalign", 1, 0, 1, 5'd9, 32'h14, 0,
              32'h102, 0);
    run_instr("nonmem", 1, 0, 0, 5'd3, 32'h18, 0,
              32'h103, NEVER);
    run_instr("timeout", 1, 0, 1, 5'd4, 32'h1C, 0,
              32'h300, NEVER);
    run_instr("ack_last", 1, 0, 1, 5'd4, 32'h20, 0,
              32'h300, TMO);
    run_instr("b2b", 0, 1, 0, 5'd0, 32'h24, 32'h55,
              32'h308, 0);

    // Reset while waiting on the bus
    drive(1, 0, 1, 5'd6, 32'h28, 0, 32'h400);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mwr.pre_req", dmem_req, 1);
      chk("mwr.pre_stall", StallM, 1);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mwr.req", dmem_req, 0);
    chk("mwr.stall", StallM, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_w("mwr.after", 0, 0, 0, 0, 0, 0, 0, 2'b00);
    end
    run_instr("mwr.fresh_tmo", 1, 0, 1, 5'd2, 32'h2C, 0,
              32'h404, NEVER);

    // Random mix of ops, alignments and ack latencies
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(2);
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      k = $urandom_range(TMO + 2);
      unique case (kind)
        0: run_instr("rnd_alu", 1, 0, 0, 5'($urandom),
                     $urandom, $urandom, a, NEVER);
        1: run_instr("rnd_load", 1, 0, 1, 5'($urandom),
                     $urandom, $urandom, a, k);
        default: run_instr("rnd_store", 0, 1, 0, 5'd0,
                           $urandom, $urandom, a, k);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
